flit_assembler: RTL



---
 rtl/flit_assembler.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/flit_assembler.sv
// Receive-side flit reassembler: per-source packet slots feeding an output FIFO.
// Optional error counter enabled with `define FLIT_ASM_ERR_CNT_EN.
module flit_assembler #(
    parameter int NODE_ID         = 0,
    parameter int NODE_COUNT      = 8,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int QUEUE_DEPTH     = 8,
    parameter int FLIT_PAYLOAD    = 8,
    parameter int MAX_PAYLOAD     = 64,
    parameter int FLIT_WIDTH      = 28,
    localparam int NW             = $clog2(NODE_COUNT),
    localparam int IDXW           = $clog2(MAX_PAYLOAD / FLIT_PAYLOAD)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [FLIT_WIDTH-1:0]      flit_in,
    input  logic                       flit_valid,
    output logic                       flit_ready,
    output logic                       pkt_valid,
    input  logic                       pkt_ready,
    output logic [MAX_PAYLOAD-1:0]     pkt_data,
    output logic [IDXW:0]              pkt_len,
    output logic [NW-1:0]              pkt_src,
    output logic [PACKET_ID_WIDTH-1:0] pkt_id,
    output logic [2:0]                 pkt_type,
    output logic [1:0]                 pkt_width,
    output logic                       err,
    output logic [15:0]                err_count
);
    localparam int PW      = $clog2(QUEUE_DEPTH);
    localparam int SRC_LSB = IDXW;
    localparam int ID_LSB  = SRC_LSB + NW;
    localparam int PL_LSB  = ID_LSB + PACKET_ID_WIDTH;
    localparam int WID_LSB = PL_LSB + FLIT_PAYLOAD;
    localparam int TYP_LSB = WID_LSB + 2;
    localparam int DST_LSB = TYP_LSB + 3;
    localparam int MRK_BIT = DST_LSB + NW;

    localparam logic [2:0] T_DMEM_REQ_READ     = 3'd0;
    localparam logic [2:0] T_DMEM_REQ_WRITE    = 3'd1;
    localparam logic [2:0] T_DMEM_RESP_DATA    = 3'd2;
    localparam logic [2:0] T_DMEM_RESP_WRITTEN = 3'd3;
    localparam logic [2:0] T_DMEM_RESP_BAD     = 3'd4;
    localparam logic [2:0] T_IMEM_REQ_READ     = 3'd5;
    localparam logic [2:0] T_IMEM_RESP_DATA    = 3'd6;
    localparam logic [2:0] T_IMEM_RESP_BAD     = 3'd7;

    typedef enum logic {S_IDLE, S_ASM} slot_state_t;

    // flit fields
    logic                       f_marker;
    logic [NW-1:0]              f_dest;
    logic [2:0]                 f_type;
    logic [1:0]                 f_width;
    logic [FLIT_PAYLOAD-1:0]    f_payload;
    logic [PACKET_ID_WIDTH-1:0] f_id;
    logic [NW-1:0]              f_src;
    logic [IDXW-1:0]            f_idx;

    assign f_marker  = flit_in[MRK_BIT];
    assign f_dest    = flit_in[DST_LSB +: NW];
    assign f_type    = flit_in[TYP_LSB +: 3];
    assign f_width   = flit_in[WID_LSB +: 2];
    assign f_payload = flit_in[PL_LSB +: FLIT_PAYLOAD];
    assign f_id      = flit_in[ID_LSB +: PACKET_ID_WIDTH];
    assign f_src     = flit_in[SRC_LSB +: NW];
    assign f_idx     = flit_in[IDXW-1:0];

    // per-source slot state
    slot_state_t                slot_state_reg [NODE_COUNT];
    logic [IDXW-1:0]            slot_next_reg  [NODE_COUNT];
    logic [IDXW:0]              slot_len_reg   [NODE_COUNT];
    logic [2:0]                 slot_type_reg  [NODE_COUNT];
    logic [1:0]                 slot_width_reg [NODE_COUNT];
    logic [PACKET_ID_WIDTH-1:0] slot_id_reg    [NODE_COUNT];
    logic [MAX_PAYLOAD-1:0]     slot_data_reg  [NODE_COUNT];

    // output FIFO
    logic [MAX_PAYLOAD-1:0]     fifo_data_reg  [QUEUE_DEPTH];
    logic [IDXW:0]              fifo_len_reg   [QUEUE_DEPTH];
    logic [NW-1:0]              fifo_src_reg   [QUEUE_DEPTH];
    logic [PACKET_ID_WIDTH-1:0] fifo_id_reg    [QUEUE_DEPTH];
    logic [2:0]                 fifo_type_reg  [QUEUE_DEPTH];
    logic [1:0]                 fifo_width_reg [QUEUE_DEPTH];
    logic [PW-1:0]              head_reg, tail_reg;
    logic [PW:0]                count_reg;

    logic                   xfer, for_me, pop;
    logic                   dec_ok;
    logic [IDXW:0]          dec_len;
    slot_state_t            cur_state, state_sel_next;
    logic                   do_start, do_append, push, err_set, err_reg;
    logic [MAX_PAYLOAD-1:0] asm_data;
    logic [IDXW:0]          last_idx;
    logic [2:0]             push_type;
    logic [1:0]             push_width;

    assign flit_ready = (count_reg < (PW+1)'(QUEUE_DEPTH)) & rst_n;
    assign xfer       = flit_valid & flit_ready;
    assign for_me     = f_marker & (f_dest == NW'(NODE_ID));
    assign pkt_valid  = (count_reg != '0);
    assign pop        = pkt_valid & pkt_ready;

    // Packet length in flits, decided by the head (idx 0) flit.
    always_comb begin
        dec_ok  = 1'b1;
        dec_len = (IDXW+1)'(1);
        case (f_type)
            T_DMEM_RESP_WRITTEN, T_DMEM_RESP_BAD, T_IMEM_RESP_BAD: dec_len = (IDXW+1)'(1);
            T_DMEM_REQ_READ, T_IMEM_REQ_READ:                      dec_len = (IDXW+1)'(4);
            T_DMEM_REQ_WRITE, T_DMEM_RESP_DATA: begin
                case (f_width)
                    2'b00:   dec_len = (IDXW+1)'(5);
                    2'b01:   dec_len = (IDXW+1)'(6);
                    2'b10:   dec_len = (IDXW+1)'(8);
                    default: dec_ok  = 1'b0;
                endcase
            end
            T_IMEM_RESP_DATA:                                      dec_len = (IDXW+1)'(8);
            default:                                               dec_ok  = 1'b0;
        endcase
    end

    // Slot FSM next-state for the slot addressed by the incoming flit.
    always_comb begin
        cur_state      = slot_state_reg[f_src];
        state_sel_next = cur_state;
        last_idx       = slot_len_reg[f_src] - (IDXW+1)'(1);
        do_start       = 1'b0;
        do_append      = 1'b0;
        push           = 1'b0;
        err_set        = 1'b0;
        if (xfer) begin
            if (!for_me) begin
                err_set = 1'b1;
            end else if (f_idx == '0) begin
                // a fresh head flit always wins over a partial packet
                if (cur_state == S_ASM) err_set = 1'b1;
                if (!dec_ok) begin
                    err_set        = 1'b1;
                    state_sel_next = S_IDLE;
                end else if (dec_len == (IDXW+1)'(1)) begin
                    push           = 1'b1;
                    state_sel_next = S_IDLE;
                end else begin
                    do_start       = 1'b1;
                    state_sel_next = S_ASM;
                end
            end else if (cur_state == S_ASM && f_idx == slot_next_reg[f_src] &&
                         f_id == slot_id_reg[f_src]) begin
                do_append = 1'b1;
                if ({1'b0, f_idx} == last_idx) begin
                    push           = 1'b1;
                    state_sel_next = S_IDLE;
                end
            end else begin
                err_set        = 1'b1;
                state_sel_next = S_IDLE;
            end
        end
    end

    always_comb begin
        asm_data = (f_idx == '0) ? '0 : slot_data_reg[f_src];
        asm_data[int'(f_idx)*FLIT_PAYLOAD +: FLIT_PAYLOAD] = f_payload;
        push_type  = (f_idx == '0) ? f_type  : slot_type_reg[f_src];
        push_width = (f_idx == '0) ? f_width : slot_width_reg[f_src];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NODE_COUNT; i++) begin
                slot_state_reg[i] <= S_IDLE;
                slot_next_reg[i]  <= '0;
                slot_len_reg[i]   <= '0;
                slot_type_reg[i]  <= '0;
                slot_width_reg[i] <= '0;
                slot_id_reg[i]    <= '0;
                slot_data_reg[i]  <= '0;
            end
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_set;
            if (xfer && for_me) slot_state_reg[f_src] <= state_sel_next;
            if (do_start) begin
                slot_next_reg[f_src]  <= (IDXW)'(1);
                slot_len_reg[f_src]   <= dec_len;
                slot_type_reg[f_src]  <= f_type;
                slot_width_reg[f_src] <= f_width;
                slot_id_reg[f_src]    <= f_id;
            end
            if (do_append) slot_next_reg[f_src] <= f_idx + (IDXW)'(1);
            if (do_start || do_append) slot_data_reg[f_src] <= asm_data;
        end
    end

    // Head entry is read straight from flops, so pkt_* stay put until popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                fifo_data_reg[i]  <= '0;
                fifo_len_reg[i]   <= '0;
                fifo_src_reg[i]   <= '0;
                fifo_id_reg[i]    <= '0;
                fifo_type_reg[i]  <= '0;
                fifo_width_reg[i] <= '0;
            end
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                fifo_data_reg[tail_reg]  <= asm_data;
                fifo_len_reg[tail_reg]   <= {1'b0, f_idx} + (IDXW+1)'(1);
                fifo_src_reg[tail_reg]   <= f_src;
                fifo_id_reg[tail_reg]    <= f_id;
                fifo_type_reg[tail_reg]  <= push_type;
                fifo_width_reg[tail_reg] <= push_width;
                tail_reg                 <= tail_reg + (PW)'(1);
            end
            if (pop) head_reg <= head_reg + (PW)'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign pkt_data  = fifo_data_reg[head_reg];
    assign pkt_len   = fifo_len_reg[head_reg];
    assign pkt_src   = fifo_src_reg[head_reg];
    assign pkt_id    = fifo_id_reg[head_reg];
    assign pkt_type  = fifo_type_reg[head_reg];
    assign pkt_width = fifo_width_reg[head_reg];
    assign err       = err_reg;

`ifdef FLIT_ASM_ERR_CNT_EN
    logic [15:0] err_count_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_count_reg <= '0;
        else if (err_set && err_count_reg != 16'hFFFF)
            err_count_reg <= err_count_reg + 16'd1;
    end
    assign err_count = err_count_reg;
`else
    assign err_count = '0;
`endif

endmodule
